hist_deriv_sequencer: RTL and testbench
=======================================

Name: hist_deriv_sequencer

Overview:
- Sequences the histogram-derivative datapath for the star-detection thresholding path.
- On start, reads NUM_BINS histogram bins from the histogram RAM, one per cycle, in ascending order.
- Streams the discrete derivative of each bin, and tracks the steepest falling edge (most negative derivative) and its bin index.
- The downstream threshold logic uses the reported peak index as the background/star cut point.

Parameters:
- NUM_BINS, 256, number of histogram bins read per run (≥2)
- BIN_W, 16, histogram bin width in bits (unsigned)
- ADDR_W, 8, bin address width; must satisfy 2**ADDR_W ≥ NUM_BINS

Ports:
- i_clk  in  1  sole clock
- i_rst_n  in  1  asynchronous active-low reset
- i_start  in  1  begin a run; sampled only in IDLE
- i_abort  in  1  cancel the run in progress
- o_busy  out  1  high from the first read cycle through the o_done cycle
- o_done  out  1  one-cycle pulse; run complete, peak outputs valid
- o_rd_en  out  1  histogram RAM read strobe
- o_rd_addr  out  ADDR_W  bin address
- i_rd_data  in  BIN_W  bin value, valid exactly 1 cycle after o_rd_en
- o_deriv_valid  out  1  derivative sample valid
- o_deriv_idx  out  ADDR_W  bin index of o_deriv
- o_deriv  out  BIN_W+1  signed derivative
- o_peak_idx  out  ADDR_W  index of the most negative derivative
- o_peak_val  out  BIN_W+1  signed value of that derivative

Behaviour:
- Clocking and reset:
  - Single clock domain.
  - Reset is asynchronous and active-low.
  - Every output resets to 0; FSM resets to IDLE.
- FSM states:
  - IDLE: on i_start=1, go to READ and clear the peak registers (idx 0, val 0).
  - READ: o_rd_en=1, o_rd_addr increments 0..NUM_BINS-1, one address per cycle. After address NUM_BINS-1 is issued, go to DRAIN.
  - DRAIN: wait until the last derivative is emitted (2 cycles), then go to DONE.
  - DONE: o_done=1 for one cycle, then go to IDLE.
- Timing, with cycle 0 = the edge sampling i_start in IDLE:
  - o_rd_en high on cycles 1..NUM_BINS.
  - Data returns on cycles 2..NUM_BINS+1.
  - o_deriv_valid high on cycles 3..NUM_BINS+2.
  - o_done on cycle NUM_BINS+3.
  - o_busy high on cycles 1..NUM_BINS+3.
  - Default configuration: done 259 cycles after start.
- Derivative:
  - d[0] = 0, since bin 0 has no predecessor.
  - d[i] = h[i] − h[i−1] for i ≥ 1, computed at BIN_W+1 bits signed. No overflow is possible.
  - The previous-bin register is loaded on every returned sample.
- Peak tracking:
  - Update when d[i] < peak_val (strict), so the earliest index wins a tie.
  - If no derivative is negative, the result is idx 0, val 0.
  - o_peak_* are registered and change only during a run. They hold their values after o_done until the next start.
- Control corner cases:
  - i_start while not in IDLE (including the DONE cycle) is ignored.
  - i_abort in READ or DRAIN: next cycle the FSM is in IDLE and o_rd_en, o_deriv_valid and o_busy are 0. No o_done pulse. Peak registers clear to 0. Any in-flight read data is discarded.
  - i_abort in IDLE or DONE has no effect; a DONE pulse still completes.
  - i_abort and i_start together in IDLE: start wins.
  - Asynchronous reset mid-run behaves like abort, with all outputs forced to 0 immediately.
- The block never stalls. The RAM must honour the fixed 1-cycle read latency.

Optional Feature:
- Macro: HIST_DERIV_SAT_EN.
- When defined:
  - The derivative is clamped to the signed BIN_W range [−2^(BIN_W−1), 2^(BIN_W−1)−1] before output and before the peak comparison.
  - It is then sign-extended onto the BIN_W+1-bit ports.
- When undefined: the full-range BIN_W+1-bit derivative is used unchanged.
- Port widths are identical in both builds.

Test Plan:
- Flat histogram, all bins = 100; start → 256 derivatives all 0; peak idx 0, val 0; o_done exactly 259 cycles after start; o_busy high for 259 cycles.
- Step histogram, h[0..9] = 5000, rest 0 → d[10] = −5000, all other d = 0; peak idx 10, val −5000.
- Tie: −300 drops at bins 20 and 40, no other negatives → peak idx 20, val −300.
- Extremes, h[0] = 0xFFFF, h[1] = 0, h[2] = 0xFFFF, rest 0xFFFF:
  - Without HIST_DERIV_SAT_EN: d[1] = −65535, d[2] = +65535, peak idx 1, val −65535.
  - With HIST_DERIV_SAT_EN: d[1] = −32768, d[2] = +32767, peak val −32768.
- Abort and restart:
  - i_abort when o_rd_addr = 100 → next cycle o_busy = 0, o_rd_en = 0, no o_done, peak = 0.
  - i_start held during the run is ignored.
  - A new start restarts reads at address 0 and completes normally.
- Reset mid-run: assert i_rst_n low asynchronously mid-cycle at address 50 → all outputs 0 immediately, FSM IDLE; after release, a start produces a correct full run.

Source files
------------

// File: rtl/hist_deriv_sequencer_if.sv
// hist_deriv_sequencer_if: histogram RAM read bus (1-cycle read latency).
interface hist_deriv_sequencer_if #(
    parameter int BIN_W  = 16,
    parameter int ADDR_W = 8
);
    logic              o_rd_en;
    logic [ADDR_W-1:0] o_rd_addr;
    logic [BIN_W-1:0]  i_rd_data;
    modport master (output o_rd_en, o_rd_addr, input i_rd_data);
    modport slave  (input o_rd_en, o_rd_addr, output i_rd_data);
endinterface

// File: rtl/hist_deriv_sequencer.sv
// hist_deriv_sequencer: reads histogram bins, streams their derivative, tracks the steepest falling edge.
// Optional macro HIST_DERIV_SAT_EN clamps the derivative to the signed BIN_W range.
module hist_deriv_sequencer #(
    parameter int NUM_BINS = 256,
    parameter int BIN_W    = 16,
    parameter int ADDR_W   = 8
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_start,
    input  logic                     i_abort,
    hist_deriv_sequencer_if.master   ram,
    output logic                     o_busy,
    output logic                     o_done,
    output logic                     o_deriv_valid,
    output logic [ADDR_W-1:0]        o_deriv_idx,
    output logic signed [BIN_W:0]    o_deriv,
    output logic [ADDR_W-1:0]        o_peak_idx,
    output logic signed [BIN_W:0]    o_peak_val
);
    typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NUM_BINS - 1);
    state_t                 state_q, state_d;
    logic [ADDR_W-1:0]      addr_q, addr_d, ridx_q, didx_q, didx_d, pidx_q, pidx_d;
    logic                   drain_q, drain_d, rv_q, rv_d, dv_q, dv_d, kill, clr;
    logic [BIN_W-1:0]       prev_q, prev_d;
    logic signed [BIN_W:0]  d_full, d_use, deriv_q, deriv_d, pval_q, pval_d;
    always_comb begin
        state_d = state_q;
        addr_d  = '0;
        drain_d = 1'b0;
        kill    = (state_q == READ || state_q == DRAIN) && i_abort;
        clr     = (state_q == IDLE && i_start) || kill;
        case (state_q)
            IDLE:  state_d = i_start ? READ : IDLE;
            READ: begin
                state_d = addr_q == LAST ? DRAIN : READ;
                addr_d  = addr_q == LAST ? '0 : addr_q + 1'b1;
            end
            DRAIN: begin
                drain_d = !drain_q;
                state_d = drain_q ? DONE : DRAIN;
            end
            default: state_d = IDLE;
        endcase
        if (kill) begin
            state_d = IDLE;
            addr_d  = '0;
            drain_d = 1'b0;
        end
    end
    // bin 0 has no predecessor, so its derivative is forced to zero
    assign d_full = ridx_q == '0 ? '0 : $signed({1'b0, ram.i_rd_data}) - $signed({1'b0, prev_q});
`ifdef HIST_DERIV_SAT_EN
    localparam logic signed [BIN_W:0] SAT_MAX = (BIN_W+1)'((1 << (BIN_W - 1)) - 1);
    localparam logic signed [BIN_W:0] SAT_MIN = ~SAT_MAX;
    assign d_use = d_full > SAT_MAX ? SAT_MAX : d_full < SAT_MIN ? SAT_MIN : d_full;
`else
    assign d_use = d_full;
`endif
    always_comb begin
        rv_d    = state_q == READ && !kill;
        dv_d    = rv_q && !kill;
        didx_d  = rv_q ? ridx_q : didx_q;
        deriv_d = rv_q ? d_use : deriv_q;
        prev_d  = rv_q ? ram.i_rd_data : prev_q;
        pidx_d  = clr ? '0 : (rv_q && d_use < pval_q) ? ridx_q : pidx_q;
        pval_d  = clr ? '0 : (rv_q && d_use < pval_q) ? d_use : pval_q;
    end
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
            drain_q <= 1'b0;
            rv_q    <= 1'b0;
            ridx_q  <= '0;
            dv_q    <= 1'b0;
            didx_q  <= '0;
            deriv_q <= '0;
            prev_q  <= '0;
            pidx_q  <= '0;
            pval_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            drain_q <= drain_d;
            rv_q    <= rv_d;
            ridx_q  <= addr_q;
            dv_q    <= dv_d;
            didx_q  <= didx_d;
            deriv_q <= deriv_d;
            prev_q  <= prev_d;
            pidx_q  <= pidx_d;
            pval_q  <= pval_d;
        end
    end
    assign o_busy        = state_q != IDLE;
    assign o_done        = state_q == DONE;
    assign ram.o_rd_en   = state_q == READ;
    assign ram.o_rd_addr = addr_q;
    assign o_deriv_valid = dv_q;
    assign o_deriv_idx   = didx_q;
    assign o_deriv       = deriv_q;
    assign o_peak_idx    = pidx_q;
    assign o_peak_val    = pval_q;
endmodule

// File: tb/tb_hist_deriv_sequencer.sv
// tb_hist_deriv_sequencer: directed runs over hand-built histograms with a 1-cycle-latency RAM model.
module tb_hist_deriv_sequencer;
    logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, abort = 1'b0;
    logic busy, done, dv;
    logic [7:0] didx, pidx;
    logic signed [16:0] deriv, pval;
    logic [15:0] mem [256];
    logic signed [16:0] got_d [256];
    int checks = 0, failures = 0, dcnt = 0, done_cnt = 0, ord_err = 0;
    int lat, busy_n, dn;
    bit ok;
    logic [7:0] last_idx = 8'd0;
    hist_deriv_sequencer_if #(.BIN_W(16), .ADDR_W(8)) bus ();
    hist_deriv_sequencer dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_abort(abort), .ram(bus),
        .o_busy(busy), .o_done(done), .o_deriv_valid(dv), .o_deriv_idx(didx),
        .o_deriv(deriv), .o_peak_idx(pidx), .o_peak_val(pval)
    );
    always #5 clk = ~clk;
    always @(posedge clk) if (bus.o_rd_en) bus.i_rd_data <= mem[bus.o_rd_addr];
    always @(negedge clk) begin
        if (dv) begin
            got_d[didx] = deriv;
            if (didx != 8'd0 && didx != last_idx + 8'd1) ord_err++;
            last_idx = didx;
            dcnt++;
        end
        if (done) done_cnt++;
    end
    task automatic chk(input string tag, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask
    function automatic longint exp_d(input int i);
        longint d = i == 0 ? 0 : longint'(mem[i]) - longint'(mem[i-1]);
`ifdef HIST_DERIV_SAT_EN
        d = d > 32767 ? 32767 : d < -32768 ? -32768 : d;
`endif
        return d;
    endfunction
    task automatic fill(input int k);
        for (int i = 0; i < 256; i++)
            case (k)
                0: mem[i] = 16'd100;
                1: mem[i] = i < 10 ? 16'd5000 : 16'd0;
                2: mem[i] = i < 20 ? 16'd1000 : i < 40 ? 16'd700 : 16'd400;
                default: mem[i] = i == 1 ? 16'h0000 : 16'hFFFF;
            endcase
    endtask
    task automatic wait_addr(input int a, output bit found);
        found = 1'b0;
        for (int i = 0; i < 400 && !found; i++) begin
            @(negedge clk);
            if (bus.o_rd_en && bus.o_rd_addr == 8'(a)) found = 1'b1;
        end
        chk("wait_addr", longint'(found), 1);
    endtask
    task automatic run(input bit hold, output int l, output int b);
        int d0 = dcnt;
        int errs = 0;
        start = 1'b1;
        @(posedge clk); #1;
        if (!hold) start = 1'b0;
        chk("first_rd", longint'({bus.o_rd_en, bus.o_rd_addr}), 'h100);
        l = 1;
        b = 0;
        while (!done && l < 400) begin
            if (busy) b++;
            @(posedge clk); #1;
            l++;
        end
        if (busy) b++;
        start = 1'b0;
        @(posedge clk); #1;
        chk("done_one_cycle", longint'({done, busy}), 0);
        for (int i = 0; i < 256; i++) if (longint'(got_d[i]) != exp_d(i)) errs++;
        chk("deriv_cnt", dcnt - d0, 256);
        chk("deriv_err", errs, 0);
    endtask
    initial begin
        #1;
        chk("rst_outs", longint'({busy, done, bus.o_rd_en, bus.o_rd_addr, dv, didx, deriv, pidx, pval}), 0);
        @(negedge clk) rst_n = 1'b1;
        fill(0);
        run(1'b1, lat, busy_n);
        chk("flat_lat", lat, 259);
        chk("flat_busy", busy_n, 259);
        chk("flat_pidx", pidx, 0);
        chk("flat_pval", pval, 0);
        fill(1);
        run(1'b0, lat, busy_n);
        chk("step_pidx", pidx, 10);
        chk("step_pval", pval, -5000);
        chk("step_d10", got_d[10], -5000);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_addr(100, ok);
        chk("pk_before_abort", pval, -5000);
        dn = done_cnt;
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        chk("abort_ctl", longint'({busy, bus.o_rd_en, dv}), 0);
        chk("abort_pidx", pidx, 0);
        chk("abort_pval", pval, 0);
        repeat (300) @(posedge clk);
        #1;
        chk("abort_no_done", done_cnt - dn, 0);
        start = 1'b1;
        abort = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        abort = 1'b0;
        chk("start_wins", longint'({busy, bus.o_rd_en, bus.o_rd_addr}), 'h300);
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        run(1'b0, lat, busy_n);
        chk("restart_lat", lat, 259);
        chk("restart_pidx", pidx, 10);
        fill(3);
        run(1'b0, lat, busy_n);
        chk("ext_pidx", pidx, 1);
`ifdef HIST_DERIV_SAT_EN
        chk("ext_d1", got_d[1], -32768);
        chk("ext_d2", got_d[2], 32767);
        chk("ext_pval", pval, -32768);
`else
        chk("ext_d1", got_d[1], -65535);
        chk("ext_d2", got_d[2], 65535);
        chk("ext_pval", pval, -65535);
`endif
        fill(2);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_addr(50, ok);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_outs", longint'({busy, done, bus.o_rd_en, bus.o_rd_addr, dv, didx, deriv, pidx, pval}), 0);
        @(negedge clk) rst_n = 1'b1;
        run(1'b0, lat, busy_n);
        chk("tie_lat", lat, 259);
        chk("tie_pidx", pidx, 20);
        chk("tie_pval", pval, -300);
        chk("deriv_order", ord_err, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
